// File: rtl/adc_clocking_uart_pkg.sv
// Shared definitions for the ADC capture / UART command block: command codes,
// UART FSM states and the reply byte layout.
package adc_clocking_uart_pkg;

    localparam logic [7:0] CMD_READ_DEFAULT = 8'h01;
    localparam logic [7:0] CMD_STREAM_ON    = 8'h02;
    localparam logic [7:0] CMD_STREAM_OFF   = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    function automatic int calc_bit_cyc(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Sample word is {OTR, ADC[11:0]}; the high reply byte carries OTR in bit 7.
    function automatic logic [7:0] reply_hi(input logic [12:0] sample);
        return {sample[12], 3'b000, sample[11:8]};
    endfunction

    function automatic logic [7:0] reply_lo(input logic [12:0] sample);
        return sample[7:0];
    endfunction

endpackage

// File: rtl/adc_clocking_uart_uart_core.sv
// 8N1 UART receiver and transmitter with mid-bit sampling and a back-to-back
// capable transmit handshake (a start request during the last stop cycle chains).
module uart_core
    import adc_clocking_uart_pkg::*;
#(
    parameter int BIT_CYC = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic       tx_line,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);

    logic          rx_meta, rx_sync, rx_prev;
    uart_state_t   rx_state, rx_state_nx;
    logic [CW-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]    rx_bit, rx_bit_nx;
    logic [7:0]    rx_shift, rx_shift_nx;
    logic          rx_valid_nx;

    uart_state_t   tx_state, tx_state_nx;
    logic [CW-1:0] tx_cnt, tx_cnt_nx;
    logic [2:0]    tx_bit, tx_bit_nx;
    logic [7:0]    tx_shift, tx_shift_nx;
    logic          tx_line_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            rx_meta  <= rx_line;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_shift <= rx_shift_nx;
            rx_valid <= rx_valid_nx;
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_shift <= tx_shift_nx;
            tx_line  <= tx_line_nx;
        end
    end

    assign rx_byte = rx_shift;

    // Receiver: start bit rechecked at half a bit to reject glitches.
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt + 1'b1;
        rx_bit_nx   = rx_bit;
        rx_shift_nx = rx_shift;
        rx_valid_nx = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                rx_cnt_nx = '0;
                if (rx_prev && !rx_sync) rx_state_nx = ST_START;
            end
            ST_START: begin
                if (rx_cnt == HALF) begin
                    rx_cnt_nx   = '0;
                    rx_bit_nx   = '0;
                    rx_state_nx = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_nx   = '0;
                    rx_shift_nx = {rx_sync, rx_shift[7:1]};
                    rx_bit_nx   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nx = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_nx   = '0;
                    rx_valid_nx = rx_sync;
                    rx_state_nx = ST_IDLE;
                end
            end
            default: rx_state_nx = ST_IDLE;
        endcase
    end

    assign tx_busy = (tx_state != ST_IDLE);
    assign tx_done = (tx_state == ST_STOP) && (tx_cnt == LAST);

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt + 1'b1;
        tx_bit_nx   = tx_bit;
        tx_shift_nx = tx_shift;
        tx_line_nx  = tx_line;
        case (tx_state)
            ST_IDLE: begin
                tx_cnt_nx = '0;
                if (tx_start) begin
                    tx_state_nx = ST_START;
                    tx_shift_nx = tx_byte;
                    tx_line_nx  = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_nx   = '0;
                    tx_bit_nx   = '0;
                    tx_state_nx = ST_DATA;
                    tx_line_nx  = tx_shift[0];
                end
            end
            ST_DATA: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_nx = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_nx = ST_STOP;
                        tx_line_nx  = 1'b1;
                    end else begin
                        tx_bit_nx  = tx_bit + 3'd1;
                        tx_line_nx = tx_shift[tx_bit + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_nx = '0;
                    if (tx_start) begin
                        tx_state_nx = ST_START;
                        tx_shift_nx = tx_byte;
                        tx_line_nx  = 1'b0;
                    end else begin
                        tx_state_nx = ST_IDLE;
                    end
                end
            end
            default: tx_state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/adc_clocking_uart.sv
// ADC clock/output-enable generation, two-stage sample capture and UART command
// decode. Optional streaming of replies (commands 0x02/0x03) under `ADC_STREAM_EN.
module adc_clocking_uart
    import adc_clocking_uart_pkg::*;
#(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         BAUD     = 1_000_000,
    parameter int         ADC_DIV  = 4,
    parameter logic [7:0] CMD_READ = CMD_READ_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ADC_OTR,
    input  logic [11:0] ADC_BIT,
    output logic        ADC_CLK,
    output logic        ADC_OE,
    input  logic        UART_RX,
    output logic        UART_TX
);
    localparam int BIT_CYC = calc_bit_cyc(CLK_HZ, BAUD);
    localparam int DW = $clog2(ADC_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(ADC_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(ADC_DIV / 2);

    logic [DW-1:0] div_cnt;
    logic          adc_clk_q, adc_oe_q;
    logic [12:0]   adc_in_q, sample_q;

    logic [7:0]    rx_byte, tx_byte;
    logic          rx_valid, tx_start, tx_busy, tx_done;
    logic          reply_active, byte_sel, send_req, start_cmd;
    logic [12:0]   tx_buf;

    // The capture edge is the one where the registered ADC_CLK falls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt   <= '0;
            adc_clk_q <= 1'b0;
            adc_oe_q  <= 1'b1;
            adc_in_q  <= '0;
            sample_q  <= '0;
        end else begin
            adc_oe_q  <= 1'b0;
            adc_clk_q <= (div_cnt < DIV_HALF);
            div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            adc_in_q  <= {ADC_OTR, ADC_BIT};
            if (div_cnt == DIV_HALF) sample_q <= adc_in_q;
        end
    end

    assign ADC_CLK = adc_clk_q;
    assign ADC_OE  = adc_oe_q;

`ifdef ADC_STREAM_EN
    logic stream_on;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stream_on <= 1'b0;
        end else if (rx_valid && rx_byte == CMD_STREAM_ON) begin
            stream_on <= 1'b1;
        end else if (rx_valid && rx_byte == CMD_STREAM_OFF) begin
            stream_on <= 1'b0;
        end
    end

    assign start_cmd = rx_valid && (rx_byte == CMD_READ || rx_byte == CMD_STREAM_ON);
`else
    assign start_cmd = rx_valid && (rx_byte == CMD_READ);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            reply_active <= 1'b0;
            byte_sel     <= 1'b0;
            send_req     <= 1'b0;
            tx_buf       <= '0;
        end else begin
            send_req <= 1'b0;
            if (start_cmd && !reply_active && !tx_busy) begin
                tx_buf       <= sample_q;
                reply_active <= 1'b1;
                byte_sel     <= 1'b0;
                send_req     <= 1'b1;
            end else if (reply_active && tx_done) begin
                if (!byte_sel) begin
                    byte_sel <= 1'b1;
`ifdef ADC_STREAM_EN
                end else if (stream_on) begin
                    tx_buf   <= sample_q;
                    byte_sel <= 1'b0;
`endif
                end else begin
                    reply_active <= 1'b0;
                    byte_sel     <= 1'b0;
                end
            end
        end
    end

    // Follow-on bytes are offered during the last stop cycle so frames chain with no gap.
    always_comb begin
        tx_start = 1'b0;
        tx_byte  = '0;
        if (send_req) begin
            tx_start = 1'b1;
            tx_byte  = reply_hi(tx_buf);
        end else if (reply_active && tx_done) begin
            if (!byte_sel) begin
                tx_start = 1'b1;
                tx_byte  = reply_lo(tx_buf);
`ifdef ADC_STREAM_EN
            end else if (stream_on) begin
                tx_start = 1'b1;
                tx_byte  = reply_hi(sample_q);
`endif
            end
        end
    end

    uart_core #(
        .BIT_CYC (BIT_CYC)
    ) u_uart (
        .clk      (CLK),
        .rst      (RST),
        .rx_line  (UART_RX),
        .tx_line  (UART_TX),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

endmodule

// File: tb/tb_adc_clocking_uart.sv
// Self-checking bench for adc_clocking_uart: directed commands on UART_RX and a
// frame-level model of the expected UART_TX reply stream.
module tb_adc_clocking_uart;

    localparam int ADC_DIV = 4;
    localparam int BIT_CYC = 50;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         refCyc;
        bit         chained;
    } reply_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ADC_OTR = 1'b0;
    logic [11:0] ADC_BIT = '0;
    logic        UART_RX = 1'b1;
    logic        ADC_CLK, ADC_OE, UART_TX;

    int     assertCount = 0;
    int     failCount = 0;
    int     cyc = 0;
    int     lastEnd = 0;
    int     txLowCycles = 0;
    reply_t expQ[$];

    adc_clocking_uart dut (
        .CLK     (CLK),
        .RST     (RST),
        .ADC_OTR (ADC_OTR),
        .ADC_BIT (ADC_BIT),
        .ADC_CLK (ADC_CLK),
        .ADC_OE  (ADC_OE),
        .UART_RX (UART_RX),
        .UART_TX (UART_TX)
    );

    always #10 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) if (!RST && UART_TX === 1'b0) txLowCycles <= txLowCycles + 1;

    task automatic checkOutput(input string name, input bit pass, input int actual, input int expected);
        assertCount++;
        if (!pass) begin
            failCount++;
            $display("[TB] FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic otr, input logic [11:0] adc);
        @(negedge CLK);
        ADC_OTR = otr;
        ADC_BIT = adc;
    endtask

    // Reply bytes from the sample word: high byte = OTR*128 + upper nibble, low byte = lower 8 bits.
    function automatic reply_t modelReply(input logic otr, input logic [11:0] adc);
        reply_t r;
        int v;
        v = adc;
        r.b0 = 8'((otr ? 128 : 0) + v / 256);
        r.b1 = 8'(v % 256);
        r.refCyc = 0;
        r.chained = 1'b0;
        return r;
    endfunction

    function automatic logic expBit(input reply_t r, input int b);
        logic [7:0] by;
        int pos;
        by = (b < 10) ? r.b0 : r.b1;
        pos = b % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[pos - 1];
    endfunction

    task automatic sendByte(input logic [7:0] data, input logic stopBit);
        UART_RX = 1'b0;
        repeat (BIT_CYC) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            UART_RX = data[i];
            repeat (BIT_CYC) @(negedge CLK);
        end
        UART_RX = stopBit;
        repeat (BIT_CYC) @(negedge CLK);
        UART_RX = 1'b1;
    endtask

    task automatic sendCommand(input logic [7:0] data, input logic stopBit, input bit expectReply, input reply_t r);
        reply_t e;
        @(negedge CLK);
        if (expectReply) begin
            e = r;
            e.refCyc = cyc;
            e.chained = 1'b0;
            expQ.push_back(e);
        end
        sendByte(data, stopBit);
    endtask

    // Checks every reply frame on UART_TX cycle by cycle against the expected queue.
    initial begin : txMonitor
        reply_t r;
        bit aborted;
        int good;
        forever begin
            @(negedge CLK);
            if (!RST && UART_TX === 1'b0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_tx_frame", 1'b0, cyc, 0);
                    for (int i = 0; i < 1000 && !RST; i++) @(negedge CLK);
                end else begin
                    r = expQ.pop_front();
                    if (r.chained)
                        checkOutput("reply_back_to_back", cyc == lastEnd + 1, cyc - lastEnd, 1);
                    else
                        checkOutput("reply_start_latency", (cyc - r.refCyc >= 475) && (cyc - r.refCyc <= 483),
                                    cyc - r.refCyc, 480);
                    aborted = 1'b0;
                    for (int b = 0; b < 20 && !aborted; b++) begin
                        good = 0;
                        for (int j = 0; j < BIT_CYC && !aborted; j++) begin
                            if (b != 0 || j != 0) @(negedge CLK);
                            if (RST) aborted = 1'b1;
                            else if (UART_TX === expBit(r, b)) good++;
                        end
                        if (!aborted)
                            checkOutput($sformatf("reply_b%0d_bit%0d_level%0d", b / 10, b % 10, expBit(r, b)),
                                        good == BIT_CYC, good, BIT_CYC);
                    end
                    lastEnd = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge CLK);
        $display("[TB] FAIL watchdog: cycle budget expired at %0d, required finish before 80000", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin : mainSeq
        reply_t r;
        int lowBefore;
        int lowAfter;

        $display("[TB] reset and ADC clocking");
        repeat (2) @(negedge CLK);
        checkOutput("reset_adc_oe", ADC_OE === 1'b1, int'(ADC_OE), 1);
        checkOutput("reset_uart_tx", UART_TX === 1'b1, int'(UART_TX), 1);
        checkOutput("reset_adc_clk", ADC_CLK === 1'b0, int'(ADC_CLK), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k == 1) checkOutput("adc_oe_after_release", ADC_OE === 1'b0, int'(ADC_OE), 0);
            checkOutput($sformatf("adc_clk_edge%0d", k), ADC_CLK === (((k - 1) % ADC_DIV) < ADC_DIV / 2),
                        int'(ADC_CLK), int'(((k - 1) % ADC_DIV) < ADC_DIV / 2));
        end

        $display("[TB] read 0x7E3, OTR=0");
        applyStimulus(1'b0, 12'h7E3);
        r.b0 = 8'h07; r.b1 = 8'hE3; r.refCyc = 0; r.chained = 1'b0;
        sendCommand(8'h01, 1'b1, 1'b1, r);
        repeat (1100) @(negedge CLK);

        $display("[TB] read 0xFFF, OTR=1");
        applyStimulus(1'b1, 12'hFFF);
        r.b0 = 8'h8F; r.b1 = 8'hFF;
        sendCommand(8'h01, 1'b1, 1'b1, r);
        repeat (1100) @(negedge CLK);

        $display("[TB] unknown byte, framing error, glitch");
        lowBefore = txLowCycles;
        sendCommand(8'h55, 1'b1, 1'b0, r);
        repeat (100) @(negedge CLK);
        sendCommand(8'h01, 1'b0, 1'b0, r);
        repeat (100) @(negedge CLK);
        UART_RX = 1'b0;
        repeat (10) @(negedge CLK);
        UART_RX = 1'b1;
        repeat (700) @(negedge CLK);
        lowAfter = txLowCycles;
        checkOutput("tx_quiet_on_bad_input", lowAfter == lowBefore, lowAfter - lowBefore, 0);

        $display("[TB] second read during reply is dropped");
        applyStimulus(1'b0, 12'h123);
        sendCommand(8'h01, 1'b1, 1'b1, modelReply(1'b0, 12'h123));
        sendCommand(8'h01, 1'b1, 1'b0, r);
        repeat (1500) @(negedge CLK);
        checkOutput("single_reply_only", expQ.size() == 0, expQ.size(), 0);

        $display("[TB] reset in the middle of byte0");
        applyStimulus(1'b0, 12'h5A5);
        sendCommand(8'h01, 1'b1, 1'b1, modelReply(1'b0, 12'h5A5));
        repeat (200) @(negedge CLK);
        checkOutput("tx_low_before_reset", UART_TX === 1'b0, int'(UART_TX), 0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("tx_high_on_reset_edge", UART_TX === 1'b1, int'(UART_TX), 1);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        lowBefore = txLowCycles;
        repeat (1200) @(negedge CLK);
        lowAfter = txLowCycles;
        checkOutput("tx_idle_after_reset", lowAfter == lowBefore, lowAfter - lowBefore, 0);
        checkOutput("adc_oe_low_after_reset", ADC_OE === 1'b0, int'(ADC_OE), 0);

`ifdef ADC_STREAM_EN
        $display("[TB] streaming on/off");
        applyStimulus(1'b0, 12'h3C1);
        r = modelReply(1'b1, 12'hABC);
        r.chained = 1'b1;
        expQ.push_back(r);
        r = modelReply(1'b0, 12'h00F);
        r.chained = 1'b1;
        expQ.push_back(r);
        @(negedge CLK);
        r = modelReply(1'b0, 12'h3C1);
        r.refCyc = cyc;
        expQ.push_front(r);
        sendByte(8'h02, 1'b1);
        repeat (280) @(negedge CLK);
        applyStimulus(1'b1, 12'hABC);
        repeat (1000) @(negedge CLK);
        applyStimulus(1'b0, 12'h00F);
        repeat (800) @(negedge CLK);
        sendCommand(8'h03, 1'b1, 1'b0, r);
        repeat (450) @(negedge CLK);
        lowBefore = txLowCycles;
        repeat (1200) @(negedge CLK);
        lowAfter = txLowCycles;
        checkOutput("stream_stopped", lowAfter == lowBefore, lowAfter - lowBefore, 0);
`else
        $display("[TB] stream commands ignored");
        lowBefore = txLowCycles;
        sendCommand(8'h02, 1'b1, 1'b0, r);
        sendCommand(8'h03, 1'b1, 1'b0, r);
        repeat (1200) @(negedge CLK);
        lowAfter = txLowCycles;
        checkOutput("stream_cmds_ignored", lowAfter == lowBefore, lowAfter - lowBefore, 0);
`endif

        checkOutput("all_replies_seen", expQ.size() == 0, expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
